// File: rtl/wishbone_pkg.sv
// Shared Wishbone bus widths and the memory-slave FSM state type.
package wishbone_pkg;
    localparam int WB_ADDR_WIDTH = 8;
    localparam int WB_DATA_WIDTH = 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_t;
endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone B4 bus bundle; signal suffixes follow the master's point of view.
interface wishbone_if
    import wishbone_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  ack_i;
    logic                  stall_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i, stall_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i, stall_i
    );
endinterface

// File: rtl/board_ram.sv
// Single-port synchronous board RAM with registered, write-first read port.
module board_ram #(
    parameter int  DEPTH      = 256,
    parameter int  DATA_WIDTH = 8,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array and read register; a write also forwards its data to the read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
        end else begin
            rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/wishbone_mem_slave.sv
// Pipelined Wishbone responder over board_ram: clears the array after reset,
// then serves one request per cycle with in-order acks READ_LATENCY cycles later.
module wishbone_mem_slave
    import wishbone_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int                    DEPTH        = 256,
    parameter int                    READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = {DATA_WIDTH{1'b0}}
) (
    input  logic       clk,
    input  logic       rst,
    wishbone_if.slave  bus,
    output logic       init_done
);
    localparam int                RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

    typedef struct packed {
        logic                  valid;
        logic                  rd_ok;
        logic [DATA_WIDTH-1:0] data;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{valid: 1'b0, rd_ok: 1'b0, data: {DATA_WIDTH{1'b0}}};

    mem_state_t            state_q, state_d;
    logic [RAM_AW-1:0]     cnt_q, cnt_d;
    slot_t                 pipe_q [READ_LATENCY];
    slot_t                 pipe_d [READ_LATENCY];
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  stall_q, stall_d;
    logic                  init_done_q, init_done_d;

    logic [ADDR_WIDTH-1:0] adr_s;
    logic                  in_range_s;
    logic                  accept_s;
    logic                  ram_we_s;
    logic [RAM_AW-1:0]     ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    slot_t                 head_s;
    slot_t                 tail_s;

    assign adr_s = bus.adr_o;

    board_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // FSM and RAM port mux: the init counter owns the write port until the array is cleared.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_s    = 1'b0;
        in_range_s  = (32'(adr_s) < 32'(DEPTH));
        ram_we_s    = 1'b0;
        ram_addr_s  = adr_s[RAM_AW-1:0];
        ram_wdata_s = bus.dat_o;
        case (state_q)
            INIT: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = cnt_q;
                ram_wdata_s = INIT_VALUE;
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + RAM_AW'(1);
                end
            end
            READY: begin
                accept_s = bus.cyc_o & bus.stb_o;
                ram_we_s = accept_s & bus.we_o & in_range_s;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        stall_d     = (state_d == INIT);
        init_done_d = (state_d == READY);
    end

    // Response pipeline: slot 0 picks up RAM read data as it advances; dropping cyc kills every slot.
    always_comb begin
        head_s      = pipe_q[0];
        head_s.data = pipe_q[0].rd_ok ? ram_rdata_s : ZERO;

        pipe_d[0].valid = accept_s;
        pipe_d[0].rd_ok = accept_s & ~bus.we_o & in_range_s;
        pipe_d[0].data  = ZERO;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = (i == 1) ? head_s : pipe_q[i-1];
        end
        tail_s = (READ_LATENCY == 1) ? head_s : pipe_q[READ_LATENCY-1];

        if (bus.cyc_o) begin
            ack_d = tail_s.valid;
            dat_d = tail_s.valid ? tail_s.data : ZERO;
        end else begin
            ack_d = 1'b0;
            dat_d = ZERO;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    // State, counter, pipeline and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= {RAM_AW{1'b0}};
            ack_q       <= 1'b0;
            dat_q       <= ZERO;
            stall_q     <= 1'b1;
            init_done_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= SLOT_IDLE;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            stall_q     <= stall_d;
            init_done_q <= init_done_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.ack_i   = ack_q;
    assign bus.dat_i   = dat_q;
    assign bus.stall_i = stall_q;
    assign init_done   = init_done_q;
endmodule

// File: tb/tb_wishbone_mem_slave.sv
// Scoreboard bench: requests push expected {data, ack cycle}; a negedge monitor pops on every ack.
module tb_wishbone_mem_slave;
    import wishbone_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done_a;
    logic init_done_b;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc_n = 0;
    int   cnt_a;
    int   cnt_b;
    int   early;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wishbone_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) a_if ();
    wishbone_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b_if ();

    wishbone_mem_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .READ_LATENCY(LAT), .INIT_VALUE(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(a_if), .init_done(init_done_a)
    );

    wishbone_mem_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200), .READ_LATENCY(LAT), .INIT_VALUE(8'h00)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(b_if), .init_done(init_done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every ack must match the oldest expectation in data and cycle; idle data must be 0.
    always @(negedge clk) begin
        if (a_if.ack_i) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected_ack: got ack with dat %0h, expected no ack", a_if.dat_i);
            end else begin
                e_a = q_a.pop_front();
                check("a_ack_data", 32'(a_if.dat_i), 32'(e_a.data));
                check("a_ack_cycle", cyc_n, e_a.due);
            end
        end else begin
            check("a_idle_dat", 32'(a_if.dat_i), 32'd0);
        end
        if (b_if.ack_i) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected_ack: got ack with dat %0h, expected no ack", b_if.dat_i);
            end else begin
                e_b = q_b.pop_front();
                check("b_ack_data", 32'(b_if.dat_i), 32'(e_b.data));
                check("b_ack_cycle", cyc_n, e_b.due);
            end
        end else begin
            check("b_idle_dat", 32'(b_if.dat_i), 32'd0);
        end
    end

    task automatic req(input int k, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                       input logic [7:0] exp_data, input bit push);
        exp_t e;
        if (k == 0) begin
            a_if.cyc_o = 1'b1; a_if.stb_o = 1'b1; a_if.we_o = we; a_if.adr_o = adr; a_if.dat_o = dat;
        end else begin
            b_if.cyc_o = 1'b1; b_if.stb_o = 1'b1; b_if.we_o = we; b_if.adr_o = adr; b_if.dat_o = dat;
        end
        @(posedge clk);
        #1;
        e.data = exp_data;
        e.due  = cyc_n + LAT;
        if (push) begin
            if (k == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        a_if.stb_o = 1'b0; a_if.we_o = 1'b0;
        b_if.stb_o = 1'b0; b_if.we_o = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int i;
        i = 0;
        while (!(init_done_a && init_done_b) && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("init_wait", 32'(init_done_a & init_done_b), 32'd1);
    endtask

    initial begin
        a_if.cyc_o = 1'b0; a_if.stb_o = 1'b0; a_if.we_o = 1'b0; a_if.adr_o = 8'h00; a_if.dat_o = 8'h00;
        b_if.cyc_o = 1'b0; b_if.stb_o = 1'b0; b_if.we_o = 1'b0; b_if.adr_o = 8'h00; b_if.dat_o = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(a_if.ack_i), 32'd0);
        check("rst_stall", 32'(a_if.stall_i), 32'd1);
        check("rst_init_done", 32'(init_done_a), 32'd0);
        rst = 1'b0;

        // Test 1: init duration (256 and 200 cycles), init_done tied to stall falling.
        cnt_a = 0; cnt_b = 0; early = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cnt_a += int'(a_if.stall_i);
            cnt_b += int'(b_if.stall_i);
            if ((init_done_a & a_if.stall_i) | (init_done_b & b_if.stall_i)) early++;
            if ((!init_done_a & !a_if.stall_i) | (!init_done_b & !b_if.stall_i)) early++;
        end
        check("init_cycles_a", cnt_a, 256);
        check("init_cycles_b", cnt_b, 200);
        check("init_done_vs_stall", early, 0);
        check("init_done_a", 32'(init_done_a), 32'd1);
        req(0, 1'b0, 8'd0,   8'h00, 8'h00, 1'b1);
        req(0, 1'b0, 8'd128, 8'h00, 8'h00, 1'b1);
        req(0, 1'b0, 8'd255, 8'h00, 8'h00, 1'b1);
        idle(5);
        check("t1_drain", q_a.size(), 0);

        // Test 2: write then read-after-write on the next cycle.
        req(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b1);
        req(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1);
        idle(5);
        check("t2_drain", q_a.size(), 0);

        // Test 3: preload 0x30..0x37, then an 8-read burst with back-to-back acks.
        for (int i = 0; i < 8; i++) req(0, 1'b1, 8'(i), 8'(8'h30 + i), 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) req(0, 1'b0, 8'(i), 8'h00, 8'(8'h30 + i), 1'b1);
        idle(12);
        check("t3_drain", q_a.size(), 0);

        // Test 4: two reads abandoned by dropping cyc, then one fresh read.
        req(0, 1'b0, 8'd0, 8'h00, 8'h00, 1'b0);
        req(0, 1'b0, 8'd1, 8'h00, 8'h00, 1'b0);
        a_if.cyc_o = 1'b0;
        a_if.stb_o = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        req(0, 1'b0, 8'd5, 8'h00, 8'h35, 1'b1);
        idle(5);
        a_if.cyc_o = 1'b0;
        check("t4_drain", q_a.size(), 0);

        // Test 5: DEPTH=200 instance, out-of-range write ignored and read returns 0.
        req(1, 1'b1, 8'd250, 8'hFF, 8'h00, 1'b1);
        req(1, 1'b0, 8'd250, 8'h00, 8'h00, 1'b1);
        req(1, 1'b1, 8'd199, 8'h5A, 8'h00, 1'b1);
        req(1, 1'b0, 8'd199, 8'h00, 8'h5A, 1'b1);
        idle(5);
        b_if.cyc_o = 1'b0;
        check("t5_drain", q_b.size(), 0);

        // Test 6: reset while acks are in flight, then re-init wipes address 0x10.
        req(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
        req(0, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0);
        a_if.stb_o = 1'b0;
        @(posedge clk);
        #2;
        check("t6_ack_before_rst", 32'(a_if.ack_i), 32'd1);
        check("t6_dat_before_rst", 32'(a_if.dat_i), 32'hA5);
        rst = 1'b1;
        #1;
        check("t6_ack_in_rst", 32'(a_if.ack_i), 32'd0);
        check("t6_stall_in_rst", 32'(a_if.stall_i), 32'd1);
        check("t6_init_done_in_rst", 32'(init_done_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_if.cyc_o = 1'b0;
        wait_init();
        req(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
        idle(5);
        check("t6_drain", q_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
